// File: rtl/alu_result_queue_pkg.sv
// Shared ALU definitions: data width and the flag bit positions
// used by the ALU and by the ALU result queue.
package alu_result_queue_pkg;

  localparam int ALU_DW    = 32;
  localparam int NFLAGS    = 3;
  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 2;

endpackage

// File: rtl/alu_result_queue_wrap_ptr.sv
// wrap_ptr: modulo-DEPTH pointer register with increment and clear.
// Ports: clk_i, rst_i, inc_i, clr_i (wins over inc_i), ptr_o.
module wrap_ptr #(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          inc_i,
  input  logic          clr_i,
  output logic [PW-1:0] ptr_o
);

  logic [PW-1:0] ptr_q, ptr_d;

  // DEPTH is a power of two, so natural overflow is the wrap.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i)      ptr_d = '0;
    else if (inc_i) ptr_d = ptr_q + PW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/alu_result_queue.sv
// alu_result_queue: FWFT FIFO of ALU {tag, flags, result} between ALU and writeback.
// Ports: clk/rst(async high)/flush; in_valid/in_ready/in_result/in_flags/in_tag;
//   out_valid/out_ready/out_result/out_flags/out_tag (zero when empty); count.
// Option ALU_STICKY_OVF_EN: adds ovf_clear (in) and ovf_sticky (out).
module alu_result_queue
  import alu_result_queue_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DW,
  parameter int DEPTH      = 4,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_result,
  input  logic [NFLAGS-1:0]      in_flags,
  input  logic [TAG_WIDTH-1:0]   in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_result,
  output logic [NFLAGS-1:0]      out_flags,
  output logic [TAG_WIDTH-1:0]   out_tag,
  output logic [$clog2(DEPTH):0] count
`ifdef ALU_STICKY_OVF_EN
  ,
  input  logic                   ovf_clear,
  output logic                   ovf_sticky
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = TAG_WIDTH + NFLAGS + DATA_WIDTH;

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count_q, count_d;
  logic          full, empty, push, pop;
  logic [EW-1:0] head;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = in_valid & ~full;
  assign pop   = out_ready & ~empty;

  wrap_ptr #(.DEPTH(DEPTH)) u_wr (
    .clk_i (clk),
    .rst_i (rst),
    .inc_i (push),
    .clr_i (flush),
    .ptr_o (wr_ptr)
  );

  wrap_ptr #(.DEPTH(DEPTH)) u_rd (
    .clk_i (clk),
    .rst_i (rst),
    .inc_i (pop),
    .clr_i (flush),
    .ptr_o (rd_ptr)
  );

  // Storage has no reset; stale contents are masked while empty.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr] <= {in_tag, in_flags, in_result};
  end

  always_comb begin
    count_d = count_q;
    if (flush)              count_d = '0;
    else if (push && !pop)  count_d = count_q + CW'(1);
    else if (pop && !push)  count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign head = empty ? '0 : mem_q[rd_ptr];

  assign in_ready   = ~full;
  assign out_valid  = ~empty;
  assign out_result = head[DATA_WIDTH-1:0];
  assign out_flags  = head[DATA_WIDTH +: NFLAGS];
  assign out_tag    = head[DATA_WIDTH+NFLAGS +: TAG_WIDTH];
  assign count      = count_q;

`ifdef ALU_STICKY_OVF_EN
  logic sticky_q, sticky_d;

  // A new overflow wins over a clear in the same cycle.
  always_comb begin
    sticky_d = sticky_q;
    if (push && in_flags[FLAG_OVF]) sticky_d = 1'b1;
    else if (ovf_clear)             sticky_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sticky_q <= 1'b0;
    else     sticky_q <= sticky_d;
  end

  assign ovf_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_alu_result_queue.sv
// Randomized + directed bench for alu_result_queue against a queue model.
// Honors ALU_STICKY_OVF_EN when defined.
module tb_alu_result_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0]  tag;
    logic [2:0]  fl;
    logic [31:0] res;
  } ent_t;

  logic        clk = 0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_result, out_result;
  logic [2:0]  in_flags, out_flags;
  logic [4:0]  in_tag, out_tag;
  logic [2:0]  count;
`ifdef ALU_STICKY_OVF_EN
  logic        ovf_clear, ovf_sticky;
  bit          sticky_m;
`endif

  ent_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_result_queue #(.DATA_WIDTH(32), .DEPTH(DEPTH), .TAG_WIDTH(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_flags   (in_flags),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .out_tag    (out_tag),
    .count      (count)
`ifdef ALU_STICKY_OVF_EN
    ,
    .ovf_clear  (ovf_clear),
    .ovf_sticky (ovf_sticky)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    ent_t h;
    h = (q.size() > 0) ? q[0] : '0;
    chk("count", 64'(count), 64'(q.size()));
    chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("out_result", 64'(out_result), 64'(h.res));
    chk("out_flags", 64'(out_flags), 64'(h.fl));
    chk("out_tag", 64'(out_tag), 64'(h.tag));
`ifdef ALU_STICKY_OVF_EN
    chk("ovf_sticky", 64'(ovf_sticky), 64'(sticky_m));
`endif
  endtask

  // Called at a negedge: apply inputs, clock once, update model, check.
  task automatic step(input bit v, input bit r, input bit f,
                      input logic [31:0] res, input logic [2:0] fl,
                      input logic [4:0] tg, input bit clr = 0);
    bit   hs_push, hs_pop;
    ent_t e;
    in_valid  = v;
    out_ready = r;
    flush     = f;
    in_result = res;
    in_flags  = fl;
    in_tag    = tg;
`ifdef ALU_STICKY_OVF_EN
    ovf_clear = clr;
`else
    if (clr) begin end
`endif
    hs_push = v && (q.size() < DEPTH);
    hs_pop  = r && (q.size() > 0);
    e = '{tag: tg, fl: fl, res: res};
    @(posedge clk);
    if (f) q.delete();
    else begin
      if (hs_pop)  void'(q.pop_front());
      if (hs_push) q.push_back(e);
    end
`ifdef ALU_STICKY_OVF_EN
    if (hs_push && fl[2]) sticky_m = 1;
    else if (clr)         sticky_m = 0;
`endif
    @(negedge clk);
    check_model();
  endtask

  initial begin
    bit seen_dead;
    rst = 1; flush = 0; in_valid = 0; out_ready = 0;
    in_result = 0; in_flags = 0; in_tag = 0;
`ifdef ALU_STICKY_OVF_EN
    ovf_clear = 0; sticky_m = 0;
`endif
    repeat (2) @(negedge clk);
    rst = 0;
    check_model();

    // Asynchronous reset in the middle of a burst
    step(1, 0, 0, 32'h11, 3'b001, 5'd1);
    step(1, 0, 0, 32'h22, 3'b010, 5'd2);
    #2 rst = 1;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(out_result), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    q.delete();
`ifdef ALU_STICKY_OVF_EN
    sticky_m = 0;
`endif
    @(negedge clk);
    rst = 0;
    check_model();

    // Fill, drop while full, drain in order
    for (int i = 1; i <= 4; i++)
      step(1, 0, 0, 32'(i), 3'(i), 5'(i + 10));
    chk("full_count", 64'(count), 64'd4);
    chk("full_ready", 64'(in_ready), 64'd0);
    step(1, 0, 0, 32'h5, 3'b0, 5'd15);
    chk("drop_count", 64'(count), 64'd4);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_res", 64'(out_result), 64'(i));
      chk("drain_tag", 64'(out_tag), 64'(i + 10));
      step(0, 1, 0, 0, 0, 0);
    end
    chk("drained", 64'(out_valid), 64'd0);

    // Push+pop at full, then steady state across the wrap
    for (int i = 0; i < 4; i++)
      step(1, 0, 0, 32'h100 + 32'(i), 3'b0, 5'(i));
    step(1, 1, 0, 32'h1FF, 3'b0, 5'd9);
    chk("full_pp_count", 64'(count), 64'd3);
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      step(1, 1, 0, 32'h200 + 32'(i), 3'(i), 5'(i));
    chk("pp_count", 64'(count), 64'd2);
    chk("pp_head", 64'(out_result), 64'h208);

    // Flags and tag stored verbatim
    step(0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 32'h8000_0000, 3'b100, 5'd31);
    chk("flag_flags", 64'(out_flags), 64'b100);
    chk("flag_tag", 64'(out_tag), 64'd31);
    chk("flag_res", 64'(out_result), 64'h8000_0000);

    // Flush beats a simultaneous push
    step(1, 1, 1, 32'hDEAD, 3'b0, 5'd3);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    step(0, 0, 0, 0, 0, 0);
    chk("no_dead", 64'(out_result == 32'hDEAD), 64'd0);

`ifdef ALU_STICKY_OVF_EN
    step(1, 0, 0, 32'h7, 3'b100, 5'd1, 1);
    chk("sticky_set", 64'(ovf_sticky), 64'd1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("sticky_clr", 64'(ovf_sticky), 64'd0);
`endif

    // Random traffic
    seen_dead = 0;
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 24) == 0, $urandom(),
           3'($urandom()), 5'($urandom()),
           $urandom_range(0, 5) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
